mips_mc_controller: RTL and testbench

//  Next-generation multicycle MIPS control unit. Fetches a 32-bit instruction over a bus
//  of BUSW bits in BEATS beats. Stalls on a memory ready handshake. Adds ADDI and BNE,
//  and traps on illegal opcodes. Drives the existing datapath control nets; one

---
 rtl/mips_pkg.sv | 56 +++++
 rtl/mips_aludec.sv | 36 +++
 rtl/mips_mc_controller.sv | 211 +++++++++++++++++++++
 tb/tb_mips_mc_controller.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared types and constants for the multicycle MIPS controller:
//   FSM state encoding, opcode and funct encodings, ALU operation classes
//   and the alucontrol codes driven to the datapath ALU.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_LBRD,
    S_LBWR,
    S_SBWR,
    S_RTYPEEX,
    S_RTYPEWR,
    S_BEQEX,
    S_BNEEX,
    S_ADDIEX,
    S_ADDIWR,
    S_JEX,
    S_TRAP
  } statetype_t;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_BNE   = 6'b000101,
    OP_ADDI  = 6'b001000,
    OP_LB    = 6'b100000,
    OP_SB    = 6'b101000
  } opcode_t;

  typedef enum logic [5:0] {
    F_ADD = 6'b100000,
    F_SUB = 6'b100010,
    F_AND = 6'b100100,
    F_OR  = 6'b100101,
    F_SLT = 6'b101010
  } functcode_t;

  // ALU operation class requested by the FSM; the ALU decoder refines it.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] ALUCTL_AND = 3'b000;
  localparam logic [2:0] ALUCTL_OR  = 3'b001;
  localparam logic [2:0] ALUCTL_ADD = 3'b010;
  localparam logic [2:0] ALUCTL_BAD = 3'b101;
  localparam logic [2:0] ALUCTL_SUB = 3'b110;
  localparam logic [2:0] ALUCTL_SLT = 3'b111;

endpackage

// File: rtl/mips_aludec.sv
// mips_aludec
//   ALU decoder: maps the FSM's ALU operation class and the instruction
//   funct field to the 3-bit alucontrol code. An unknown funct in an
//   R-type execute yields ALUCTL_BAD (101).
// Ports
//   aluop       in  2  operation class from the controller FSM
//   funct       in  6  instr[5:0]
//   alucontrol  out 3  ALU operation select
module mips_aludec
  import mips_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [5:0]  funct,
  output logic [2:0]  alucontrol
);

  always_comb begin
    alucontrol = ALUCTL_BAD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALUCTL_ADD;
      ALUOP_SUB: alucontrol = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alucontrol = ALUCTL_ADD;
          F_SUB:   alucontrol = ALUCTL_SUB;
          F_AND:   alucontrol = ALUCTL_AND;
          F_OR:    alucontrol = ALUCTL_OR;
          F_SLT:   alucontrol = ALUCTL_SLT;
          default: alucontrol = ALUCTL_BAD;
        endcase
      end
      default: alucontrol = ALUCTL_BAD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// mips_mc_controller
//   Multicycle MIPS control unit. Fetches a 32-bit instruction over a
//   BUSW-bit memory bus in BEATS beats, stalling on mem_ready, then
//   sequences the datapath for LB, SB, R-type, BEQ, BNE, ADDI and J.
//   Any other opcode enters an absorbing TRAP state left only by reset.
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   op, funct, zero       instruction fields and ALU zero flag
//   mem_ready             memory accepts/returns this cycle
//   memread, memwrite     memory strobes, held until mem_ready
//   alusrca, alusrcb      ALU operand selects
//   alucontrol            ALU operation
//   memtoreg, iord        write-back data select, address select
//   regwrite, regdst      register file write enable and destination
//   pcsrc, pcen           next-PC select and PC enable
//   irwrite               one-hot instruction-register beat enable
//   trap                  sticky illegal-opcode flag
//   All outputs are forced to 0 while rst_n is low.
module mips_mc_controller
  import mips_pkg::*;
#(
  parameter int  BUSW   = 8,
  parameter int  INSTRW = 32,
  localparam int BEATS  = INSTRW / BUSW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             memread,
  output logic             memwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [2:0]       alucontrol,
  output logic             memtoreg,
  output logic             iord,
  output logic             regwrite,
  output logic             regdst,
  output logic [1:0]       pcsrc,
  output logic             pcen,
  output logic [BEATS-1:0] irwrite,
  output logic             trap
);

  if (INSTRW % BUSW != 0) begin : g_bad_busw
    $error("mips_mc_controller: BUSW (%0d) must divide INSTRW (%0d)", BUSW, INSTRW);
  end

  localparam int                BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  statetype_t        state, state_next;
  logic [BEAT_W-1:0] beat, beat_next;
  logic              pcwrite, branch, isbne;
  aluop_t            aluop;
  logic [2:0]        alu_ctl;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      beat  <= '0;
    end else begin
      state <= state_next;
      beat  <= beat_next;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can infer a latch.
    state_next = state;
    beat_next  = beat;
    memread    = 1'b0;
    memwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    memtoreg   = 1'b0;
    iord       = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    pcsrc      = 2'b00;
    irwrite    = '0;
    trap       = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    isbne      = 1'b0;
    aluop      = ALUOP_ADD;

    unique case (state)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        // A stalled beat writes nothing and advances nothing.
        if (mem_ready) begin
          irwrite = BEATS'(1) << beat;
          pcwrite = 1'b1;
          if (beat == LAST_BEAT) begin
            beat_next  = '0;
            state_next = S_DECODE;
          end else begin
            beat_next = beat + 1'b1;
          end
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LB, OP_SB: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_RTYPEEX;
          OP_BEQ:       state_next = S_BEQEX;
          OP_BNE:       state_next = S_BNEEX;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JEX;
          default:      state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = (op == OP_SB) ? S_SBWR : S_LBRD;
      end
      S_LBRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_next = S_LBWR;
      end
      S_LBWR: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        state_next = S_FETCH;
      end
      S_SBWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_FUNCT;
        state_next = S_RTYPEWR;
      end
      S_RTYPEWR: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = S_ADDIWR;
      end
      S_ADDIWR: begin
        regwrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQEX, S_BNEEX: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        isbne      = (state == S_BNEEX);
        state_next = S_FETCH;
      end
      S_JEX: begin
        pcwrite    = 1'b1;
        pcsrc      = 2'b10;
        state_next = S_FETCH;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        // Unused encodings are treated as a fault.
        state_next = S_TRAP;
      end
    endcase

    // BNE takes the branch on a non-zero compare, BEQ on a zero one.
    pcen = pcwrite | (branch & (zero ^ isbne));

    // Reset silences every output at once, aborting any memory transfer
    // without waiting for a clock edge.
    if (!rst_n) begin
      memread  = 1'b0;
      memwrite = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      memtoreg = 1'b0;
      iord     = 1'b0;
      regwrite = 1'b0;
      regdst   = 1'b0;
      pcsrc    = 2'b00;
      pcen     = 1'b0;
      irwrite  = '0;
      trap     = 1'b0;
    end
  end

  mips_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alu_ctl)
  );

  assign alucontrol = rst_n ? alu_ctl : 3'b000;

endmodule

// File: tb/tb_mips_mc_controller.sv
// tb_mips_mc_controller
//   Scoreboard bench for mips_mc_controller. Two instances are exercised:
//   BUSW=8 (four fetch beats) and BUSW=32 (one beat). The stimulus process
//   walks whole instructions (fetch beats with optional stalls, decode,
//   execute steps), pushing the expected control vector for every cycle
//   into a per-instance queue; a monitor pops and compares on the falling
//   edge. Expected vectors come from the instruction-level behaviour of
//   each instruction class, not from a state machine.
module tb_mips_mc_controller;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic       memtoreg;
    logic       iord;
    logic       regwrite;
    logic       regdst;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [3:0] irwrite;
    logic       trap;
  } ctl_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_SB   = 6'b101000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v  [2];
  logic [5:0] op_v   [2];
  logic [5:0] fn_v   [2];
  logic       zero_v [2];
  logic       rdy_v  [2];
  ctl_t       act    [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int BW  = (g == 0) ? 8 : 32;
    localparam int NBT = 32 / BW;
    logic             memread, memwrite, alusrca, memtoreg, iord;
    logic             regwrite, regdst, pcen, trap;
    logic [1:0]       alusrcb, pcsrc;
    logic [2:0]       alucontrol;
    logic [NBT-1:0]   irwrite;

    mips_mc_controller #(.BUSW(BW), .INSTRW(32)) dut (
      .clk        (clk),
      .rst_n      (rst_v[g]),
      .op         (op_v[g]),
      .funct      (fn_v[g]),
      .zero       (zero_v[g]),
      .mem_ready  (rdy_v[g]),
      .memread    (memread),
      .memwrite   (memwrite),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .alucontrol (alucontrol),
      .memtoreg   (memtoreg),
      .iord       (iord),
      .regwrite   (regwrite),
      .regdst     (regdst),
      .pcsrc      (pcsrc),
      .pcen       (pcen),
      .irwrite    (irwrite),
      .trap       (trap)
    );

    assign act[g] = {memread, memwrite, alusrca, alusrcb, alucontrol, memtoreg,
                     iord, regwrite, regdst, pcsrc, pcen, 4'(irwrite), trap};
  end

  ctl_t q0[$];
  ctl_t q1[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(string name, ctl_t got, ctl_t want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @%0t: got %05h expected %05h (differing bits %05h)",
               name, $time, got, want, got ^ want);
    end
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) check("busw8_ctl", act[0], q0.pop_front());
    if (q1.size() > 0) check("busw32_ctl", act[1], q1.pop_front());
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: stimulus did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model helpers ----------------
  function automatic int nbeats(int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // With no ALU request the ALU is left adding.
  function automatic ctl_t idle();
    ctl_t e;
    e = '0;
    e.alucontrol = 3'b010;
    return e;
  endfunction

  function automatic logic [2:0] funct_ctl(logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b101;
    endcase
  endfunction

  function automatic logic is_legal(logic [5:0] o);
    return o inside {OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LB, OP_SB};
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] o;
    case ($urandom_range(0, 7))
      0: o = OP_R;
      1: o = OP_J;
      2: o = OP_BEQ;
      3: o = OP_BNE;
      4: o = OP_ADDI;
      5: o = OP_LB;
      6: o = OP_SB;
      default: begin
        o = 6'($urandom);
        while (is_legal(o)) o = 6'($urandom);
      end
    endcase
    return o;
  endfunction

  function automatic logic [5:0] pick_funct();
    case ($urandom_range(0, 5))
      0: return 6'b100000;
      1: return 6'b100010;
      2: return 6'b100100;
      3: return 6'b100101;
      4: return 6'b101010;
      default: return 6'($urandom);
    endcase
  endfunction

  // One clock cycle of stimulus plus its expected control vector.
  task automatic cyc(int d, logic r, logic z, logic m, ctl_t e);
    rst_v[d]  = r;
    zero_v[d] = z;
    rdy_v[d]  = m;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Instruction fetch: each beat may be preceded by stall cycles.
  task automatic fetch(int d, int stall_beat, int stall_n, bit rnd);
    ctl_t e;
    op_v[d] = 6'($urandom);
    fn_v[d] = 6'($urandom);
    for (int b = 0; b < nbeats(d); b++) begin
      int waits;
      waits = (b == stall_beat) ? stall_n : (rnd ? int'($urandom_range(0, 2)) : 0);
      e = idle();
      e.memread = 1'b1;
      e.alusrcb = 2'b01;
      repeat (waits) cyc(d, 1'b1, rbit(), 1'b0, e);
      e.irwrite = 4'(1 << b);
      e.pcen    = 1'b1;
      cyc(d, 1'b1, rbit(), 1'b1, e);
    end
  endtask

  // Decode and execute one instruction. mem_wait stall cycles precede the
  // memory handshake; rst_at (>=0) pulses reset on that memory cycle.
  // Illegal opcodes trap for trap_n cycles, then reset is pulsed.
  task automatic exec(int d, logic [5:0] o, logic [5:0] f, logic z,
                      int mem_wait, int rst_at, int trap_n);
    ctl_t e;
    op_v[d] = o;
    fn_v[d] = f;
    e = idle();
    e.alusrcb = 2'b11;
    cyc(d, 1'b1, rbit(), rbit(), e);
    case (o)
      OP_LB, OP_SB: begin
        e = idle();
        e.alusrca = 1'b1;
        e.alusrcb = 2'b10;
        cyc(d, 1'b1, rbit(), rbit(), e);
        e = idle();
        e.iord = 1'b1;
        if (o == OP_LB) e.memread = 1'b1;
        else            e.memwrite = 1'b1;
        for (int k = 0; k <= mem_wait; k++) begin
          if (k == rst_at) begin
            cyc(d, 1'b0, rbit(), 1'b1, '0);
            return;
          end
          cyc(d, 1'b1, rbit(), (k == mem_wait), e);
        end
        if (o == OP_LB) begin
          e = idle();
          e.regwrite = 1'b1;
          e.memtoreg = 1'b1;
          cyc(d, 1'b1, rbit(), rbit(), e);
        end
      end
      OP_R: begin
        e = idle();
        e.alusrca    = 1'b1;
        e.alucontrol = funct_ctl(f);
        cyc(d, 1'b1, rbit(), rbit(), e);
        e = idle();
        e.regdst   = 1'b1;
        e.regwrite = 1'b1;
        cyc(d, 1'b1, rbit(), rbit(), e);
      end
      OP_ADDI: begin
        e = idle();
        e.alusrca = 1'b1;
        e.alusrcb = 2'b10;
        cyc(d, 1'b1, rbit(), rbit(), e);
        e = idle();
        e.regwrite = 1'b1;
        cyc(d, 1'b1, rbit(), rbit(), e);
      end
      OP_BEQ, OP_BNE: begin
        e = idle();
        e.alusrca    = 1'b1;
        e.alucontrol = 3'b110;
        e.pcsrc      = 2'b01;
        e.pcen       = (o == OP_BEQ) ? z : ~z;
        cyc(d, 1'b1, z, rbit(), e);
      end
      OP_J: begin
        e = idle();
        e.pcen  = 1'b1;
        e.pcsrc = 2'b10;
        cyc(d, 1'b1, rbit(), rbit(), e);
      end
      default: begin
        e = idle();
        e.trap = 1'b1;
        repeat (trap_n) cyc(d, 1'b1, rbit(), rbit(), e);
        cyc(d, 1'b0, rbit(), rbit(), '0);
      end
    endcase
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_v[d]  = 1'b0;
      op_v[d]   = '0;
      fn_v[d]   = '0;
      zero_v[d] = 1'b0;
      rdy_v[d]  = 1'b0;
    end
    @(posedge clk);
    #1;

    // ---- BUSW=8 instance ----
    repeat (2) cyc(0, 1'b0, rbit(), rbit(), '0);       // outputs silent in reset
    fetch(0, -1, 0, 1'b0);                              // four back-to-back beats
    exec(0, OP_J, 6'd0, 1'b0, 0, -1, 0);
    fetch(0, 2, 3, 1'b0);                               // beat 2 stalls three cycles
    exec(0, OP_ADDI, 6'd0, 1'b0, 0, -1, 0);
    fetch(0, -1, 0, 1'b0);
    exec(0, OP_BNE, 6'd0, 1'b0, 0, -1, 0);              // taken
    fetch(0, -1, 0, 1'b0);
    exec(0, OP_BNE, 6'd0, 1'b1, 0, -1, 0);              // not taken
    fetch(0, -1, 0, 1'b0);
    exec(0, OP_BEQ, 6'd0, 1'b0, 0, -1, 0);              // not taken
    fetch(0, -1, 0, 1'b0);
    exec(0, OP_BEQ, 6'd0, 1'b1, 0, -1, 0);              // taken
    fetch(0, -1, 0, 1'b0);
    exec(0, OP_LB, 6'd0, 1'b0, 2, -1, 0);
    fetch(0, -1, 0, 1'b0);
    exec(0, OP_SB, 6'd0, 1'b0, 2, -1, 0);               // memwrite held three cycles
    fetch(0, -1, 0, 1'b0);
    exec(0, OP_SB, 6'd0, 1'b0, 2, 1, 0);                // reset aborts the store
    fetch(0, -1, 0, 1'b0);
    exec(0, 6'b111111, 6'd0, 1'b0, 0, -1, 20);          // trap, then reset pulse
    fetch(0, -1, 0, 1'b0);
    exec(0, OP_R, 6'b100101, 1'b0, 0, -1, 0);
    repeat (40) begin
      fetch(0, -1, 0, 1'b1);
      exec(0, pick_op(), pick_funct(), rbit(), int'($urandom_range(0, 3)), -1, 3);
    end

    // ---- BUSW=32 instance ----
    repeat (2) cyc(1, 1'b0, rbit(), rbit(), '0);
    fetch(1, -1, 0, 1'b0);
    exec(1, OP_R, 6'b100010, 1'b0, 0, -1, 0);           // sub
    fetch(1, 0, 2, 1'b0);
    exec(1, OP_R, 6'b111111, 1'b0, 0, -1, 0);           // unknown funct
    fetch(1, -1, 0, 1'b0);
    exec(1, 6'b010001, 6'd0, 1'b0, 0, -1, 5);
    repeat (40) begin
      fetch(1, -1, 0, 1'b1);
      exec(1, pick_op(), pick_funct(), rbit(), int'($urandom_range(0, 3)), -1, 3);
    end

    // Every pushed expectation must have been consumed by the monitor.
    @(negedge clk);
    #1;
    n_cmp++;
    if (q0.size() + q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q0.size() + q1.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
